// File: rtl/s_bus_arbiter_if.sv
// s_bus_arbiter_if -- request/serial bus bundle between two requesters and
// the shared-serial-bus arbiter.
//   req[1:0]      requester -> arbiter  bus request (bit i = requester i)
//   sen_in[1:0]   requester -> arbiter  serial enable per requester
//   sd_in[1:0]    requester -> arbiter  serial data per requester
//   grant[1:0]    arbiter -> requester  one-hot or zero grant
//   sen, sd       arbiter -> bus        shared serial enable / data
//   busy          arbiter status        not idle
//   frame_done    arbiter status        pulse on normal frame end
//   timeout_err   arbiter status        pulse on forced release
//   frame_cnt     arbiter status        completed frame count (wraps)
interface s_bus_arbiter_if;
    logic [1:0] req;
    logic [1:0] sen_in;
    logic [1:0] sd_in;
    logic [1:0] grant;
    logic       sen;
    logic       sd;
    logic       busy;
    logic       frame_done;
    logic       timeout_err;
    logic [7:0] frame_cnt;

    modport master (
        output req, sen_in, sd_in,
        input  grant, sen, sd, busy, frame_done, timeout_err, frame_cnt
    );

    modport slave (
        input  req, sen_in, sd_in,
        output grant, sen, sd, busy, frame_done, timeout_err, frame_cnt
    );
endinterface

// File: rtl/s_bus_arbiter.sv
// s_bus_arbiter -- two-requester round-robin arbiter for a shared serial bus.
// The granted requester's sen_in/sd_in are forwarded through one register
// stage onto sen/sd. A frame ends normally when the granted sen_in falls after
// having been high, is cancelled if the request drops before any enable, and
// is forcibly released after MAX_FRAME cycles. Each release is followed by
// GAP idle cycles before the next grant can be issued.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous reset, active low
//   bus   s_bus_arbiter_if.slave (requests in, grant/serial/status out)
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | no grant; arbitrate any pending request
// ST_ACTIVE | one requester owns the bus; forward its serial lines
// ST_GAP    | bus released; hold off new grants for GAP cycles
module s_bus_arbiter #(
    parameter int unsigned MAX_FRAME = 32,
    parameter int unsigned GAP       = 2
) (
    input  logic            clk,
    input  logic            rst,
    s_bus_arbiter_if.slave  bus
);

    localparam int unsigned CNT_MAX = (MAX_FRAME > GAP) ? MAX_FRAME : GAP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(MAX_FRAME - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic             sen_q, sen_d;
    logic             sd_q, sd_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;
    logic             timeout_err_q, timeout_err_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             seen_q, seen_d;
    logic             last_q, last_d;

    logic             owner;
    logic             g_req;
    logic             g_sen;
    logic             g_sd;
    logic             winner;

    // Only the owner's lines are looked at; the other requester is ignored.
    assign owner = grant_q[1];
    assign g_req = bus.req[owner];
    assign g_sen = bus.sen_in[owner];
    assign g_sd  = bus.sd_in[owner];

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        sen_d         = 1'b0;
        sd_d          = 1'b0;
        frame_done_d  = 1'b0;
        timeout_err_d = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        cnt_d         = cnt_q;
        seen_d        = seen_q;
        last_d        = last_q;
        winner        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    // On a tie the requester not served last wins; a lone
                    // requester wins outright (req[1] alone -> 1, else 0).
                    winner  = (bus.req == 2'b11) ? ~last_q : bus.req[1];
                    grant_d = winner ? 2'b10 : 2'b01;
                    last_d  = winner;
                    state_d = ST_ACTIVE;
                    cnt_d   = '0;
                    seen_d  = 1'b0;
                end
            end

            ST_ACTIVE: begin
                // Priority: normal end, then cancel, then timeout.
                if (seen_q && !g_sen) begin
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + 8'd1;
                    grant_d      = 2'b00;
                    state_d      = ST_GAP;
                    cnt_d        = '0;
                end else if (!seen_q && !g_req) begin
                    grant_d = 2'b00;
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else if (cnt_q == FRAME_LAST) begin
                    timeout_err_d = 1'b1;
                    grant_d       = 2'b00;
                    state_d       = ST_GAP;
                    cnt_d         = '0;
                end else begin
                    sen_d  = g_sen;
                    sd_d   = g_sd;
                    seen_d = seen_q | g_sen;
                    cnt_d  = cnt_q + CNT_W'(1);
                end
            end

            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            grant_q       <= 2'b00;
            sen_q         <= 1'b0;
            sd_q          <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            frame_cnt_q   <= 8'd0;
            cnt_q         <= '0;
            seen_q        <= 1'b0;
            last_q        <= 1'b1;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            sen_q         <= sen_d;
            sd_q          <= sd_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            timeout_err_q <= timeout_err_d;
            frame_cnt_q   <= frame_cnt_d;
            cnt_q         <= cnt_d;
            seen_q        <= seen_d;
            last_q        <= last_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.sen         = sen_q;
    assign bus.sd          = sd_q;
    assign bus.busy        = busy_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.frame_cnt   = frame_cnt_q;

endmodule
